apb_ram_completer: RTL and testbench
====================================

// Module: apb_ram_completer
// PURPOSE
//   APB4 completer (slave) backed by a word-organised RAM. It is the memory-side end of the
//   core's load/store path: the core's APB requester drives psel/penable, and this block
//   returns pready/prdata/pslverr, which become the core's mem_ready and load data.
//   Programmable wait states exercise the core's S_MEM_WAIT / S_MEM_WRITE stall paths.
// PARAMETERS
//   BASE_ADDR    32'h0001_0000  byte address of word 0; must be a multiple of MEM_WORDS*4
//   MEM_WORDS    1024           RAM depth in 32-bit words (power of 2, >= 2)
//   WAIT_STATES  1              access-phase cycles with pready=0 before completion (0..15)
// PORTS
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   psel     in   1   APB select
//   penable  in   1   APB enable (access phase)
//   pwrite   in   1   1=write, 0=read
//   paddr    in   32  byte address
//   pwdata   in   32  write data
//   pstrb    in   4   byte write strobes; pstrb[i] enables byte pwdata[8i+7:8i]
//   prdata   out  32  read data; valid only while pready=1 and the transfer is a read
//   pready   out  1   transfer complete this cycle
//   pslverr  out  1   error response; valid only while pready=1
// BEHAVIOUR
// - Reset: rst is synchronous, active-high, clock clk. On reset: state<=IDLE, cnt<=0,
//   pready=0, pslverr=0, prdata=0. RAM contents are not reset.
//   A transfer in flight at reset is dropped and no write is committed.
// - States: IDLE, ACCESS.
//   IDLE: outputs are 0. If psel=1 and penable=0 (setup) at a rising edge:
//     * latch pwrite, pstrb, and pwdata
//     * latch idx = (paddr-BASE_ADDR)>>2, masked to $clog2(MEM_WORDS) bits
//     * latch err = (paddr[1:0]!=0) || (paddr < BASE_ADDR) || (paddr >= BASE_ADDR+MEM_WORDS*4)
//     * rdata_q <= mem[idx]
//     * cnt <= WAIT_STATES
//     * go to ACCESS
//     psel=1 with penable=1 seen in IDLE is a protocol error: ignore it and stay in IDLE.
//   ACCESS:
//     * If psel=0 or penable=0, abort: go to IDLE with no write and pready=0.
//     * Else if cnt!=0: pready=0 and cnt<=cnt-1.
//     * Else (cnt==0): complete. pready=1 and pslverr=err.
//       prdata = rdata_q for a read with no error; otherwise prdata=0.
//       For a write with no error, at this edge write each byte of mem[idx] whose pstrb bit
//       is set. Then go to IDLE.
// - pready, pslverr and prdata are combinational from state, cnt, err, and the latched
//   fields. They are low (0) in every other cycle.
// - Latency: the completing cycle is setup+1+WAIT_STATES. With WAIT_STATES=0, pready=1 in
//   the first access cycle (zero-wait APB).
// - Back-to-back: a new setup in the cycle right after completion is accepted with no bubble.
// - pstrb=4'b0000 on a write completes normally with pslverr=0 and leaves RAM unchanged.
//   pstrb on reads is ignored.
// - An error transfer never modifies RAM. Errors are address-only; pwrite does not affect err.
// - cnt width is max(1,$clog2(WAIT_STATES+1)) bits and never wraps, because ACCESS exits
//   at cnt==0.
// - Read-after-write to the same word in consecutive transfers returns the new data,
//   because rdata_q is sampled at the later setup edge.
// TESTING
// 1. WAIT_STATES=0: write 32'hDEADBEEF to 0x0001_0010 with pstrb=4'hF, then read it back.
//    Required: pready in the first access cycle of each transfer, prdata=32'hDEADBEEF,
//    pslverr=0.
// 2. WAIT_STATES=3: read 0x0001_0010.
//    Required: pready=0 for 3 access cycles, then 1 on the 4th; prdata valid only in that
//    cycle and 0 otherwise.
// 3. Byte strobes: write 32'h11223344 with pstrb=4'h5 over a word holding 32'hAABBCCDD.
//    Required: a read returns 32'hAA22CC44.
// 4. Errors: access 0x0001_0012 (misaligned), 0x0000_FFFC (below base), and
//    BASE_ADDR+MEM_WORDS*4.
//    Required: each returns pready=1, pslverr=1, prdata=0. A following read shows the
//    target RAM word unchanged.
// 5. Abort/reset: with WAIT_STATES=2, deassert psel mid-ACCESS on a write; separately,
//    assert rst mid-ACCESS on a write.
//    Required: no RAM change, pready never asserted, and the next setup is accepted.
// 6. Back-to-back: write then read of the same word, with the read setup in the cycle after
//    the write's pready.
//    Required: the read is accepted with no idle cycle and returns the newly written data.

Source files
------------

// File: rtl/apb_ram_completer_if.sv
// APB4 completer-side bus bundle: requester drives the request fields,
// completer answers with pready/prdata/pslverr.
interface apb_ram_completer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_completer.sv
// APB4 completer backed by a word-organised RAM with byte strobes and a
// programmable number of wait states in the access phase.
module apb_ram_completer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  apb_ram_completer_if.slave apb
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

  // 33-bit window bounds so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [3:0]       strb_q;
  logic [31:0]      wdata_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic [31:0] mem [MEM_WORDS];

  logic             accept;
  logic             commit;
  logic [IDX_W-1:0] idx_in;
  logic             err_in;
  logic             pready_c;
  logic             pslverr_c;
  logic [31:0]      prdata_c;

  assign idx_in = IDX_W'((apb.paddr - BASE_ADDR) >> 2);
  assign err_in = (apb.paddr[1:0] != 2'b00)
                | ({1'b0, apb.paddr} < LO_ADDR)
                | ({1'b0, apb.paddr} >= HI_ADDR);

  // Next-state, wait countdown and completion response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    commit    = 1'b0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    prdata_c  = 32'h0;
    case (state_q)
      IDLE: begin
        // psel with penable already high here is a protocol violation: ignored.
        if (apb.psel && !apb.penable) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!(apb.psel && apb.penable)) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pready_c  = 1'b1;
          pslverr_c = err_q;
          prdata_c  = (!write_q && !err_q) ? rdata_q : 32'h0;
          commit    = write_q && !err_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign apb.pready  = pready_c;
  assign apb.pslverr = pslverr_c;
  assign apb.prdata  = prdata_c;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields at the setup edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      strb_q  <= 4'h0;
      wdata_q <= 32'h0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= apb.pwrite;
      strb_q  <= apb.pstrb;
      wdata_q <= apb.pwdata;
      idx_q   <= idx_in;
      err_q   <= err_in;
    end
  end

  // RAM: registered read at setup, byte-strobed write at completion.
  // Reset suppresses a completing write so a reset mid-transfer never commits.
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_q <= mem[idx_in];
    end
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_completer.sv
// Bench: three completers (0, 3 and 2 wait states) driven by directed
// transfers; a per-cycle compare process checks every output against the
// expectations derived from a word-level memory model.
module tb_apb_ram_completer;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WORDS = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        psel_a    [3];
  logic        penable_a [3];
  logic        pwrite_a  [3];
  logic [31:0] paddr_a   [3];
  logic [31:0] pwdata_a  [3];
  logic [3:0]  pstrb_a   [3];
  logic [31:0] prdata_a  [3];
  logic        pready_a  [3];
  logic        pslverr_a [3];

  logic        exp_rdy [3];
  logic        exp_err [3];
  logic [31:0] exp_dat [3];
  logic [31:0] last_rd [3];
  logic        last_err[3];

  logic [31:0] mm [int];
  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      apb_ram_completer_if bus ();
      assign bus.psel     = psel_a[gi];
      assign bus.penable  = penable_a[gi];
      assign bus.pwrite   = pwrite_a[gi];
      assign bus.paddr    = paddr_a[gi];
      assign bus.pwdata   = pwdata_a[gi];
      assign bus.pstrb    = pstrb_a[gi];
      assign prdata_a[gi]  = bus.prdata;
      assign pready_a[gi]  = bus.pready;
      assign pslverr_a[gi] = bus.pslverr;
      apb_ram_completer #(
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (WORDS),
        .WAIT_STATES(ws_of(gi))
      ) dut (
        .clk(clk),
        .rst(rst),
        .apb(bus)
      );
    end
  endgenerate

  // Per-cycle comparison of every completer against its expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        vectors += 3;
        if (pready_a[d] !== exp_rdy[d]) begin
          fails++;
          $display("FAIL pready dut%0d t=%0t: got %b want %b", d, $time, pready_a[d], exp_rdy[d]);
        end
        if (pslverr_a[d] !== exp_err[d]) begin
          fails++;
          $display("FAIL pslverr dut%0d t=%0t: got %b want %b", d, $time, pslverr_a[d], exp_err[d]);
        end
        if (prdata_a[d] !== exp_dat[d]) begin
          fails++;
          $display("FAIL prdata dut%0d t=%0t: got %h want %h", d, $time, prdata_a[d], exp_dat[d]);
        end
        if (pready_a[d] === 1'b1) begin
          last_rd[d]  = prdata_a[d];
          last_err[d] = pslverr_a[d];
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_exp(input int d, input logic r, input logic e, input logic [31:0] v);
    exp_rdy[d] = r;
    exp_err[d] = e;
    exp_dat[d] = v;
  endtask

  // One APB transfer; abort_k / rst_k pick the access cycle to abort or reset in (-1 = none).
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int abort_k = -1, input int rst_k = -1);
    int ws = ws_of(d);
    bit err = (addr[1:0] != 2'b00) || (addr < BASE) || ({1'b0, addr} >= {1'b0, BASE} + 33'(WORDS * 4));
    int idx = int'(((addr - BASE) >> 2) & 32'(WORDS - 1));
    int key = d * WORDS + idx;
    logic [31:0] rd = (!wr && !err && mm.exists(key)) ? mm[key] : 32'h0;
    logic [31:0] nw;
    string how = "done";
    last_rd[d]  = 32'h0;
    last_err[d] = 1'b0;
    psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = wr;
    paddr_a[d] = addr; pwdata_a[d] = wdata; pstrb_a[d] = strb;
    set_exp(d, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k <= ws; k++) begin
      if (k == abort_k) begin
        psel_a[d] = 1'b0; penable_a[d] = 1'b0;
        set_exp(d, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        how = "aborted";
        break;
      end
      penable_a[d] = 1'b1;
      if (k == rst_k) rst = 1'b1;
      if (k == ws) set_exp(d, 1'b1, err, (!wr && !err) ? rd : 32'h0);
      else         set_exp(d, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      if (k == rst_k) begin
        rst = 1'b0;
        how = "reset";
        break;
      end
      if (k == ws && wr && !err) begin
        nw = mm.exists(key) ? mm[key] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) nw[8*b +: 8] = wdata[8*b +: 8];
        mm[key] = nw;
      end
    end
    psel_a[d] = 1'b0; penable_a[d] = 1'b0;
    set_exp(d, 1'b0, 1'b0, 32'h0);
    $display("xfer dut%0d ws=%0d %s addr=%h wdata=%h strb=%h err=%0d exp_rdata=%h %s",
             d, ws, wr ? "WR" : "RD", addr, wdata, strb, err, rd, how);
  endtask

  task automatic proto_err(input int d);
    psel_a[d] = 1'b1; penable_a[d] = 1'b1; pwrite_a[d] = 1'b1;
    paddr_a[d] = BASE; pwdata_a[d] = 32'hBAD0BAD0; pstrb_a[d] = 4'hF;
    set_exp(d, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    psel_a[d] = 1'b0; penable_a[d] = 1'b0;
    $display("xfer dut%0d protocol-error enable without setup, ignored", d);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      psel_a[d] = 0; penable_a[d] = 0; pwrite_a[d] = 0;
      paddr_a[d] = 0; pwdata_a[d] = 0; pstrb_a[d] = 0;
      set_exp(d, 1'b0, 1'b0, 32'h0);
      last_rd[d] = 0; last_err[d] = 0;
    end
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait write/read.
    xfer(0, 1, 32'h0001_0010, 32'hDEADBEEF, 4'hF);
    xfer(0, 0, 32'h0001_0010, 32'h0, 4'h0);
    check32("ws0 readback", last_rd[0], 32'hDEADBEEF);

    // Byte strobes.
    xfer(0, 1, 32'h0001_0020, 32'hAABBCCDD, 4'hF);
    xfer(0, 1, 32'h0001_0020, 32'h11223344, 4'h5);
    check32("model strobe merge", mm[8], 32'hAA22CC44);
    xfer(0, 0, 32'h0001_0020, 32'h0, 4'hF);
    check32("strobe readback", last_rd[0], 32'hAA22CC44);

    // Error accesses: misaligned aliases word 4, out-of-range aliases word 0.
    xfer(0, 1, 32'h0001_0000, 32'h5555AAAA, 4'hF);
    xfer(0, 1, 32'h0001_0012, 32'h0BAD0BAD, 4'hF);
    check32("misaligned pslverr", {31'h0, last_err[0]}, 32'h1);
    xfer(0, 0, 32'h0000_FFFC, 32'h0, 4'h0);
    check32("below-base pslverr", {31'h0, last_err[0]}, 32'h1);
    xfer(0, 1, BASE + WORDS * 4, 32'hFFFFFFFF, 4'hF);
    check32("above-top pslverr", {31'h0, last_err[0]}, 32'h1);
    xfer(0, 0, 32'h0001_0010, 32'h0, 4'h0);
    check32("misaligned no write", last_rd[0], 32'hDEADBEEF);
    xfer(0, 0, 32'h0001_0000, 32'h0, 4'h0);
    check32("out-of-range no write", last_rd[0], 32'h5555AAAA);

    // Zero strobes leave the word alone.
    xfer(0, 1, 32'h0001_0010, 32'h01234567, 4'h0);
    xfer(0, 0, 32'h0001_0010, 32'h0, 4'h0);
    check32("pstrb0 no change", last_rd[0], 32'hDEADBEEF);

    // Back-to-back write then read of the same word.
    xfer(0, 1, 32'h0001_0030, 32'h12345678, 4'hF);
    xfer(0, 0, 32'h0001_0030, 32'h0, 4'h0);
    check32("b2b read new data", last_rd[0], 32'h12345678);

    // Three wait states.
    xfer(1, 1, 32'h0001_0010, 32'hCAFEF00D, 4'hF);
    xfer(1, 0, 32'h0001_0010, 32'h0, 4'h0);
    check32("ws3 readback", last_rd[1], 32'hCAFEF00D);

    // Two wait states: protocol error, abort and reset mid-access.
    xfer(2, 1, 32'h0001_0040, 32'h01020304, 4'hF);
    proto_err(2);
    xfer(2, 1, 32'h0001_0040, 32'hFFFFFFFF, 4'hF, 1, -1);
    xfer(2, 0, 32'h0001_0040, 32'h0, 4'h0);
    check32("abort no write", last_rd[2], 32'h01020304);
    xfer(2, 1, 32'h0001_0040, 32'hEEEEEEEE, 4'hF, -1, 1);
    xfer(2, 0, 32'h0001_0040, 32'h0, 4'h0);
    check32("reset no write", last_rd[2], 32'h01020304);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
